// File: rtl/fc2_argmax.sv
// fc2_argmax: final classification stage after fc_top.
// On an fc2_done pulse it reads CLASS_NUM packed signed scores from SRAM f,
// keeps a running maximum (lowest index wins ties) and presents the winner
// with a one-cycle class_valid pulse.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   fc2_done     in   start pulse (sampled only in IDLE)
//   sram_rdata_f in   SRAM f read data, valid one cycle after the address is sampled
//   sram_raddr_f out  SRAM f read address (registered)
//   busy         out  high from start acceptance until class_valid
//   class_valid  out  one-cycle pulse when class_id/class_score are new
//   class_id     out  index of the maximum score
//   class_score  out  maximum score (signed)
module fc2_argmax #(
  parameter int unsigned     DATA_WIDTH             = 8,
  parameter int unsigned     DATA_NUM_PER_SRAM_ADDR = 4,
  parameter int unsigned     CLASS_NUM              = 10,
  parameter logic [9:0]      BASE_ADDR              = 10'd0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         fc2_done,
  input  logic [DATA_WIDTH*DATA_NUM_PER_SRAM_ADDR-1:0] sram_rdata_f,
  output logic [9:0]                                   sram_raddr_f,
  output logic                                         busy,
  output logic                                         class_valid,
  output logic [3:0]                                   class_id,
  output logic signed [DATA_WIDTH-1:0]                 class_score
);

  localparam int unsigned WORD_W = DATA_WIDTH * DATA_NUM_PER_SRAM_ADDR;
  localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ISSUE, CMP0, CMP1, CMP2} state_t;

  state_t state, state_next;

  logic signed [DATA_WIDTH-1:0] run_max;
  logic [3:0]                   run_idx;
  logic signed [DATA_WIDTH-1:0] cand_max;
  logic [3:0]                   cand_idx;
  logic signed [DATA_WIDTH-1:0] score;
  int unsigned                  word_base;
  int unsigned                  idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fc2_done) state_next = ISSUE;
      ISSUE:   state_next = CMP0;
      CMP0:    state_next = CMP1;
      CMP1:    state_next = CMP2;
      CMP2:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Chain the bytes of the current word in ascending index order; strict '>'
  // keeps the earliest index on ties. Slots past CLASS_NUM (tail of the last
  // word) are masked so padding can never win.
  always_comb begin
    cand_max  = run_max;
    cand_idx  = run_idx;
    score     = '0;
    idx       = 0;
    case (state)
      CMP1:    word_base = DATA_NUM_PER_SRAM_ADDR;
      CMP2:    word_base = 2 * DATA_NUM_PER_SRAM_ADDR;
      default: word_base = 0;
    endcase
    for (int unsigned i = 0; i < DATA_NUM_PER_SRAM_ADDR; i++) begin
      score = sram_rdata_f[WORD_W-1-i*DATA_WIDTH -: DATA_WIDTH];
      idx   = word_base + i;
      if (idx < CLASS_NUM && score > cand_max) begin
        cand_max = score;
        cand_idx = 4'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sram_raddr_f <= BASE_ADDR;
      busy         <= 1'b0;
      class_valid  <= 1'b0;
      class_id     <= '0;
      class_score  <= MIN_SCORE;
      run_max      <= MIN_SCORE;
      run_idx      <= '0;
    end else begin
      class_valid <= 1'b0;
      case (state)
        IDLE: begin
          sram_raddr_f <= BASE_ADDR;
          if (fc2_done) begin
            busy    <= 1'b1;
            run_max <= MIN_SCORE;
            run_idx <= '0;
          end
        end
        ISSUE: sram_raddr_f <= BASE_ADDR + 10'd1;
        CMP0: begin
          sram_raddr_f <= BASE_ADDR + 10'd2;
          run_max      <= cand_max;
          run_idx      <= cand_idx;
        end
        CMP1: begin
          run_max <= cand_max;
          run_idx <= cand_idx;
        end
        CMP2: begin
          sram_raddr_f <= BASE_ADDR;
          class_id     <= cand_idx;
          class_score  <= cand_max;
          class_valid  <= 1'b1;
          busy         <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fc2_argmax.sv
// Directed bench for fc2_argmax: registered SRAM model, hand-computed
// expected class/score, latency, abort and back-to-back behaviour.
module tb_fc2_argmax;

  localparam logic [9:0] BASE = 10'd4;

  logic        clk = 1'b0;
  logic        rst;
  logic        fc2_done;
  logic [31:0] sram_rdata_f;
  logic [9:0]  sram_raddr_f;
  logic        busy;
  logic        class_valid;
  logic [3:0]  class_id;
  logic [7:0]  class_score;

  logic [31:0] mem [0:15];
  int vectors = 0;
  int miscompares = 0;

  fc2_argmax #(
    .DATA_WIDTH(8),
    .DATA_NUM_PER_SRAM_ADDR(4),
    .CLASS_NUM(10),
    .BASE_ADDR(BASE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fc2_done(fc2_done),
    .sram_rdata_f(sram_rdata_f),
    .sram_raddr_f(sram_raddr_f),
    .busy(busy),
    .class_valid(class_valid),
    .class_id(class_id),
    .class_score(class_score)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM: data appears one cycle after the address is sampled.
  // Unloaded words read as 0x7F bytes so a wrong address would win the compare.
  always @(posedge clk)
    sram_rdata_f <= (sram_raddr_f < 10'd16) ? mem[sram_raddr_f[3:0]] : 32'h7F7F_7F7F;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] s [10], input logic [15:0] garbage);
    mem[BASE[3:0]]      = {s[0], s[1], s[2], s[3]};
    mem[BASE[3:0] + 1]  = {s[4], s[5], s[6], s[7]};
    mem[BASE[3:0] + 2]  = {s[8], s[9], garbage};
  endtask

  task automatic run(input string tag, input logic [3:0] eid, input logic [7:0] esc);
    int n;
    fc2_done = 1'b1;
    @(negedge clk);
    fc2_done = 1'b0;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (n < 12 && !class_valid) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_id"}, 32'(class_id), 32'(eid));
    check({tag, "_score"}, 32'(class_score), 32'(esc));
    check({tag, "_busy_end"}, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  logic [7:0] sc [10];
  logic [9:0] raddr_log [18];
  logic       valid_log [18];
  int         pulses;
  int         first_p;
  int         second_p;

  initial begin
    rst = 1'b1;
    fc2_done = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h7F7F_7F7F;
    @(negedge clk);
    @(negedge clk);
    check("rst_id", 32'(class_id), 32'd0);
    check("rst_score", 32'(class_score), 32'h80);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(class_valid), 32'd0);
    check("rst_raddr", 32'(sram_raddr_f), 32'(BASE));
    rst = 1'b0;
    @(negedge clk);

    sc = '{8'hFD, 8'h05, 8'h0C, 8'h07, 8'h00, 8'hF8, 8'h5A, 8'h04, 8'h0B, 8'h02};
    load(sc, 16'h0000);
    run("basic", 4'd6, 8'h5A);

    sc = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    load(sc, 16'h8080);
    run("all_min", 4'd0, 8'h80);

    sc = '{8'h00, 8'h00, 8'h00, 8'h7F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h7F};
    load(sc, 16'h0000);
    run("tie", 4'd3, 8'h7F);

    sc = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd99, 8'd100};
    load(sc, 16'hFFFF);
    run("last_ffff", 4'd9, 8'd100);
    load(sc, 16'h7F7F);
    run("last_7f7f", 4'd9, 8'd100);

    sc = '{8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'hF9, 8'hF8, 8'hF7, 8'hF6};
    load(sc, 16'h0000);
    run("neg", 4'd0, 8'hFF);

    sc = '{8'h80, 8'h80, 8'h7F, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    load(sc, 16'h8080);
    run("sign", 4'd2, 8'h7F);

    // Re-pulse during CMP0 must be ignored; results only change at the pulse.
    sc = '{8'hFD, 8'h05, 8'h0C, 8'h07, 8'h00, 8'hF8, 8'h5A, 8'h04, 8'h0B, 8'h02};
    load(sc, 16'h0000);
    fc2_done = 1'b1;
    @(negedge clk);
    fc2_done = 1'b0;
    @(negedge clk);
    fc2_done = 1'b1;
    @(negedge clk);
    fc2_done = 1'b0;
    check("repulse_hold_id", 32'(class_id), 32'd2);
    check("repulse_hold_score", 32'(class_score), 32'h7F);
    @(negedge clk);
    check("repulse_n3_valid", 32'(class_valid), 32'd0);
    @(negedge clk);
    check("repulse_n4_valid", 32'(class_valid), 32'd1);
    check("repulse_id", 32'(class_id), 32'd6);
    check("repulse_score", 32'(class_score), 32'h5A);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (class_valid) pulses++;
    end
    check("repulse_no_restart", pulses, 0);
    check("repulse_idle_busy", 32'(busy), 32'd0);

    // Reset during CMP1 aborts the run with no class_valid.
    sc = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h32, 8'h00, 8'h00, 8'h00, 8'h00};
    load(sc, 16'h0000);
    fc2_done = 1'b1;
    @(negedge clk);
    fc2_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_id", 32'(class_id), 32'd0);
    check("abort_score", 32'(class_score), 32'h80);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_raddr", 32'(sram_raddr_f), 32'(BASE));
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (class_valid) pulses++;
    end
    check("abort_no_valid", pulses, 0);
    run("after_abort", 4'd5, 8'h32);

    // fc2_done held for 8 edges: two back-to-back runs, pulses 5 cycles apart.
    for (int i = 0; i < 18; i++) begin
      fc2_done = (i < 8);
      @(negedge clk);
      raddr_log[i] = sram_raddr_f;
      valid_log[i] = class_valid;
    end
    fc2_done = 1'b0;
    pulses = 0;
    first_p = -1;
    second_p = -1;
    for (int i = 0; i < 18; i++) begin
      if (valid_log[i]) begin
        pulses++;
        if (first_p < 0) first_p = i;
        else if (second_p < 0) second_p = i;
      end
    end
    check("b2b_pulses", pulses, 2);
    check("b2b_first", first_p, 4);
    check("b2b_gap", second_p - first_p, 5);
    check("b2b_raddr0", 32'(raddr_log[0]), 32'(BASE));
    check("b2b_raddr1", 32'(raddr_log[1]), 32'(BASE + 10'd1));
    check("b2b_raddr2", 32'(raddr_log[2]), 32'(BASE + 10'd2));
    check("b2b_raddr5", 32'(raddr_log[5]), 32'(BASE));
    check("b2b_raddr6", 32'(raddr_log[6]), 32'(BASE + 10'd1));
    check("b2b_raddr7", 32'(raddr_log[7]), 32'(BASE + 10'd2));
    check("b2b_id", 32'(class_id), 32'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
